// File: rtl/exception_ctrl.sv
// exception_ctrl: MEM/WB exception initiator. Prioritises per-instruction
// exception flags and qualified interrupts, drives one registered commit
// cycle into CP0, then holds flush_o for FLUSH_LEN cycles with the redirect
// PC on new_pc_o.
// Ports: clk, rst (sync, active-high); stall_i, mem_* instruction context and
// exception flags; status_i/cause_i/epc_i plus the wb_cp0_* forwarding path;
// excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o (CP0
// commit); flush_o, new_pc_o (pipeline redirect).
// Optional: define EXC_COUNTER_EN to add exc_count_o (committed non-eret count).
module exception_ctrl #(
    parameter int          FLUSH_LEN  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_adel_if_i,
    input  logic        mem_ri_i,
    input  logic        mem_ov_i,
    input  logic        mem_trap_i,
    input  logic        mem_syscall_i,
    input  logic        mem_break_i,
    input  logic        mem_adel_ld_i,
    input  logic        mem_ades_i,
    input  logic        mem_eret_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
`ifdef EXC_COUNTER_EN
    output logic [31:0] exc_count_o,
`endif
    output logic [31:0] new_pc_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_DRAIN  = 2'd2
    } state_e;

    localparam logic [3:0] DRAIN_INIT =
        (FLUSH_LEN >= 2) ? 4'(FLUSH_LEN - 2) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  code_q;
    logic [31:0] pc_q;
    logic        ds_q;
    logic [31:0] bad_q;
    logic [31:0] npc_q;

    logic [31:0] st_eff, cause_eff, epc_eff;
    logic        irq;
    logic [3:0]  code_c;
    logic [31:0] bad_c;
    logic        cap;

    // WB mtc0 forwarding; Cause only exposes the software-writable bits.
    always_comb begin
        st_eff    = status_i;
        cause_eff = cause_i;
        epc_eff   = epc_i;
        if (wb_cp0_we_i) begin
            if (wb_cp0_waddr_i == 5'd12) st_eff = wb_cp0_data_i;
            if (wb_cp0_waddr_i == 5'd13) begin
                cause_eff[9:8] = wb_cp0_data_i[9:8];
                cause_eff[22]  = wb_cp0_data_i[22];
                cause_eff[23]  = wb_cp0_data_i[23];
            end
            if (wb_cp0_waddr_i == 5'd14) epc_eff = wb_cp0_data_i;
        end
    end

    assign irq = st_eff[0] & ~st_eff[1]
               & (|(cause_eff[15:8] & st_eff[15:8]));

    // Priority chain; code 0 means no candidate.
    always_comb begin
        code_c = 4'h0;
        bad_c  = 32'h0;
        if (mem_valid_i) begin
            if (irq)                code_c = 4'h1;
            else if (mem_adel_if_i) begin
                code_c = 4'h4;
                bad_c  = mem_pc_i;
            end
            else if (mem_ri_i)      code_c = 4'ha;
            else if (mem_ov_i)      code_c = 4'hc;
            else if (mem_trap_i)    code_c = 4'hd;
            else if (mem_syscall_i) code_c = 4'h8;
            else if (mem_break_i)   code_c = 4'h9;
            else if (mem_adel_ld_i) begin
                code_c = 4'h4;
                bad_c  = mem_addr_i;
            end
            else if (mem_ades_i) begin
                code_c = 4'h5;
                bad_c  = mem_addr_i;
            end
            else if (mem_eret_i)    code_c = 4'he;
        end
    end

    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        cap                 = 1'b0;
        excepttype_o        = 32'h0;
        current_inst_addr_o = 32'h0;
        is_in_delayslot_o   = 1'b0;
        bad_addr_o          = 32'h0;
        flush_o             = 1'b0;
        new_pc_o            = 32'h0;
        unique case (state_q)
            S_IDLE: begin
                if (code_c != 4'h0 && !stall_i) begin
                    cap     = 1'b1;
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                excepttype_o        = {28'h0, code_q};
                current_inst_addr_o = pc_q;
                is_in_delayslot_o   = ds_q;
                bad_addr_o          = bad_q;
                flush_o             = 1'b1;
                new_pc_o            = npc_q;
                if (FLUSH_LEN <= 1) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = DRAIN_INIT;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                flush_o  = 1'b1;
                new_pc_o = npc_q;
                if (cnt_q == 4'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            code_q  <= 4'h0;
            pc_q    <= 32'h0;
            ds_q    <= 1'b0;
            bad_q   <= 32'h0;
            npc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cap) begin
                code_q <= code_c;
                pc_q   <= mem_pc_i;
                ds_q   <= mem_in_delayslot_i;
                bad_q  <= bad_c;
                npc_q  <= (code_c == 4'he) ? epc_eff : EXC_VECTOR;
            end
        end
    end

`ifdef EXC_COUNTER_EN
    logic [31:0] cnt_exc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_exc_q <= 32'h0;
        end else if (state_q == S_COMMIT && code_q != 4'he) begin
            cnt_exc_q <= cnt_exc_q + 32'd1;
        end
    end

    assign exc_count_o = cnt_exc_q;
`endif

    logic unused_ok;
    assign unused_ok = ^{st_eff[31:16], st_eff[7:2],
                         cause_eff[31:16], cause_eff[7:0]};

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Exception initiator for the CP0 register file. It sits at the MEM/WB boundary and collects per-instruction exception flags plus pending interrupts, qualifying the interrupts against forwarded Status/Cause. For each committed exception it drives exactly one registered commit cycle into CP0 (`excepttype`, `current_inst_addr`, `is_in_delayslot`, `bad_addr`). It then holds the pipeline flush for a programmable drain window and supplies the redirect PC.

## Interface
Parameters:
- `FLUSH_LEN`, 2 — total cycles `flush_o` is high per exception, including the commit cycle; legal range 1..15.
- `EXC_VECTOR`, 32'hBFC00380 — redirect target for all exceptions except eret.

Ports:
- `clk` input 1 — sole clock.
- `rst` input 1 — synchronous, active-high reset.
- `stall_i` input 1 — MEM stage held; no capture while high.
- `mem_valid_i` input 1 — MEM holds a real (non-bubble) instruction.
- `mem_pc_i` input 32 — PC of the MEM instruction.
- `mem_in_delayslot_i` input 1 — MEM instruction is in a branch delay slot.
- `mem_addr_i` input 32 — load/store effective address.
- `mem_adel_if_i`, `mem_ri_i`, `mem_ov_i`, `mem_trap_i`, `mem_syscall_i`, `mem_break_i`, `mem_adel_ld_i`, `mem_ades_i`, `mem_eret_i` input 1 each — exception flags.
- `status_i`, `cause_i`, `epc_i` input 32 each — CP0 register outputs.
- `wb_cp0_we_i` input 1, `wb_cp0_waddr_i` input 5, `wb_cp0_data_i` input 32 — CP0 write in flight in WB; forwarded.
- `excepttype_o` output 32 — exception code to CP0; 0 means none.
- `current_inst_addr_o` output 32, `is_in_delayslot_o` output 1, `bad_addr_o` output 32 — exception context to CP0.
- `flush_o` output 1 — kills IF..WB, including the WB write and the data-memory write enable in that cycle.
- `new_pc_o` output 32 — redirect PC; valid when `flush_o` is high.

## Operation
- Forwarding: when `wb_cp0_we_i` is high and `wb_cp0_waddr_i` is 12, 13 or 14, the effective Status, Cause or EPC is `wb_cp0_data_i`.
  - Cause forwarding replaces only bits 9:8, 22 and 23.
- Interrupt pending when all of the following hold:
  - eff Status[0] = 1
  - eff Status[1] = 0
  - (eff Cause[15:8] & eff Status[15:8]) != 0
- Candidate exception is selected only when `mem_valid_i` is 1. Priority, high to low, with codes:
  - interrupt 0x1
  - AdEL-fetch 0x4
  - RI 0xa
  - OV 0xc
  - trap 0xd
  - syscall 0x8
  - break 0x9
  - AdEL-load 0x4
  - AdES 0x5
  - eret 0xe
- `bad_addr` source:
  - AdEL-fetch: `mem_pc_i`.
  - AdEL-load and AdES: `mem_addr_i`.
  - All other codes: 0.
- `new_pc`: eret gives eff EPC; all others give `EXC_VECTOR`.
- FSM states: IDLE, COMMIT, DRAIN; a 4-bit drain counter.
  - IDLE: if a candidate exists and `stall_i` = 0, register code, `mem_pc_i`, delay-slot flag, bad_addr and new_pc, then go to COMMIT. Otherwise stay in IDLE.
  - COMMIT (exactly 1 cycle): `excepttype_o`, `current_inst_addr_o`, `is_in_delayslot_o` and `bad_addr_o` show the captured values; `flush_o` = 1.
    - If `FLUSH_LEN` = 1, go to IDLE.
    - Otherwise load counter with `FLUSH_LEN`-2 and go to DRAIN.
  - DRAIN: `excepttype_o` = 0, `flush_o` = 1, `new_pc_o` held. Counter decrements each cycle; at 0, go to IDLE.
    - `stall_i` and all inputs are ignored.
- Outside COMMIT, `excepttype_o`, `current_inst_addr_o`, `is_in_delayslot_o` and `bad_addr_o` are 0. Outside COMMIT/DRAIN, `flush_o` = 0 and `new_pc_o` = 0.
- Exceptions arriving during COMMIT or DRAIN are dropped; flushed instructions re-execute after the redirect.

## Timing
- Latency: candidate accepted at edge N appears on the CP0 ports for cycle N+1; CP0 commits at the edge ending N+1.
- `flush_o` is high for exactly `FLUSH_LEN` consecutive cycles, starting at N+1.
- Earliest next capture is the first IDLE cycle after the drain.
- `stall_i` high in IDLE holds capture. The candidate is re-evaluated each cycle; an interrupt may deassert before capture and is then not taken.
- Reset: all outputs 0, state IDLE, counter 0. Reset asserted in COMMIT or DRAIN returns to IDLE at the next edge with no commit.
- Simultaneous flags: only the highest-priority flag is reported.
- Simultaneous WB mtc0 write to Status/Cause/EPC in the capture cycle: the forwarded value is used.

## Configuration
- `EXC_COUNTER_EN` defined: adds output `exc_count_o` (32 bits).
  - Reset value 0.
  - Increments by 1 in each COMMIT cycle whose code is not 0xe; wraps from 32'hFFFFFFFF to 0.
- `EXC_COUNTER_EN` undefined: the port and the counter do not exist; all other behaviour is identical.

## Test plan
- Syscall: `mem_valid_i`=1, `mem_syscall_i`=1, `mem_pc_i`=0xBFC00100, delay-slot=0 → next cycle `excepttype_o`=0x8, `current_inst_addr_o`=0xBFC00100, `new_pc_o`=0xBFC00380. `flush_o` high for 2 cycles; `excepttype_o`=0 in the second.
- Priority and bad_addr: RI, OV and AdES set together, `mem_addr_i`=0x80000003 → `excepttype_o`=0xa, `bad_addr_o`=0. AdES alone → code 0x5, `bad_addr_o`=0x80000003.
- Interrupt forwarding: `status_i`=0, WB mtc0 to reg 12 with data 0x0000FF01, `cause_i`[10]=1 → `excepttype_o`=0x1. The same case with forwarded Status[1]=1 gives no commit.
- Eret with forwarded EPC: WB mtc0 to reg 14 with data 0xBFC00500, `mem_eret_i`=1 → `excepttype_o`=0xe, `new_pc_o`=0xBFC00500.
- Stall and drain: flag held with `stall_i`=1 for 3 cycles → no commit; commit on the cycle after `stall_i` falls. With `FLUSH_LEN`=4, a flag during DRAIN is dropped and `flush_o` is exactly 4 cycles.
- Reset in DRAIN → IDLE and all outputs 0 next cycle. With `EXC_COUNTER_EN`, 3 exceptions plus 1 eret → `exc_count_o`=3.
